// File: rtl/pk_poci.sv
// Shared POCI widths, arbiter state encoding and default timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   ADDR_W / DATA_W  : POCI address and data bus widths
//   TIMEOUT_DEFAULT  : ACCESS cycles to wait for pready before erroring
//   state_e          : arbiter transfer phase
//   req_t / rsp_t    : captured request and response bundles
package pk_poci;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Request fields captured from the winning requester at grant time.
  typedef struct packed {
    addr_t paddr;
    logic  pwrite;
    data_t pwdata;
  } req_t;

  // Response captured from the target (or synthesised on timeout).
  typedef struct packed {
    data_t prdata;
    logic  pslverr;
  } rsp_t;

endpackage

// File: rtl/if_poci.sv
// POCI bus bundle shared by requesters, the arbiter and the target.
// Latency: n/a (wires only).
// Backpressure: target stretches ACCESS by holding pready low.
//
// Modports:
//   master : drives psel/penable/paddr/pwrite/pwdata, receives pready/prdata/pslverr
//   slave  : receives the request, drives the response
interface if_poci;
  import pk_poci::*;

  logic  psel;
  logic  penable;
  addr_t paddr;
  logic  pwrite;
  data_t pwdata;
  logic  pready;
  data_t prdata;
  logic  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/poci_arbiter.sv
// Two-requester round-robin POCI arbiter in front of one shared target.
// Latency: request sampled at edge k -> SETUP k+1, ACCESS k+2, requester pready k+3 (zero wait).
// Backpressure: target wait states stretch ACCESS up to TIMEOUT cycles, then an error response.
//
// Ports:
//   pclk, presetn : clock, asynchronous active-low reset
//   m0, m1        : requester side (arbiter acts as their target)
//   s             : shared target (arbiter acts as its requester)
module poci_arbiter
  import pk_poci::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT  // 1..255 ACCESS cycles
) (
  input  logic   pclk,
  input  logic   presetn,
  if_poci.slave  m0,
  if_poci.slave  m1,
  if_poci.master s
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_e     state_q, state_d;
  logic       grant_q, grant_d;            // owner of the transfer in flight
  logic       last_grant_q, last_grant_d;  // loser-priority pointer for ties
  logic [7:0] cnt_q, cnt_d;                // ACCESS cycles already spent
  req_t       req_q, req_d;
  rsp_t       rsp_q, rsp_d;

  // ------------------------------------------------------------------
  // Request view
  // ------------------------------------------------------------------
  logic [1:0] req_vld;
  req_t       m0_req, m1_req;
  logic       arb_vld;
  logic       arb_idx;
  logic       acc_timeout;
  logic       unused_penable;

  // penable from a requester carries no arbitration meaning.
  assign unused_penable = m0.penable | m1.penable;

  assign req_vld = {m1.psel, m0.psel};
  assign m0_req  = '{paddr: m0.paddr, pwrite: m0.pwrite, pwdata: m0.pwdata};
  assign m1_req  = '{paddr: m1.paddr, pwrite: m1.pwrite, pwdata: m1.pwdata};

  // This ACCESS cycle is the last one allowed before the error response.
  assign acc_timeout = ((cnt_q + 8'd1) == TIMEOUT_CNT);

  // ------------------------------------------------------------------
  // Round-robin pick: a lone requester wins, a tie goes to whoever was
  // not served last.
  // ------------------------------------------------------------------
  always_comb begin
    arb_vld = |req_vld;
    arb_idx = 1'b0;
    case (req_vld)
      2'b01:   arb_idx = 1'b0;
      2'b10:   arb_idx = 1'b1;
      2'b11:   arb_idx = ~last_grant_q;
      default: arb_idx = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_vld) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (s.pready || acc_timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath next values
  // ------------------------------------------------------------------
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    rsp_d        = rsp_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          req_d        = arb_idx ? m1_req : m0_req;
          cnt_d        = 8'd0;
        end
      end
      ACCESS: begin
        // A response arriving on the final allowed cycle beats the timeout.
        if (s.pready) begin
          rsp_d = '{prdata: s.prdata, pslverr: s.pslverr};
        end else if (acc_timeout) begin
          rsp_d = '{prdata: '0, pslverr: 1'b1};
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 8'd0;
      req_q        <= '0;
      rsp_q        <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      rsp_q        <= rsp_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: outputs (all decoded from registered state, so reset clears
  // them without waiting for a clock)
  // ------------------------------------------------------------------
  always_comb begin
    s.psel     = (state_q == SETUP) || (state_q == ACCESS);
    s.penable  = (state_q == ACCESS);
    s.paddr    = req_q.paddr;
    s.pwrite   = req_q.pwrite;
    s.pwdata   = req_q.pwdata;

    m0.pready  = 1'b0;
    m0.prdata  = '0;
    m0.pslverr = 1'b0;
    m1.pready  = 1'b0;
    m1.prdata  = '0;
    m1.pslverr = 1'b0;

    if (state_q == DONE) begin
      if (grant_q) begin
        m1.pready  = 1'b1;
        m1.prdata  = rsp_q.prdata;
        m1.pslverr = rsp_q.pslverr;
      end else begin
        m0.pready  = 1'b1;
        m0.prdata  = rsp_q.prdata;
        m0.pslverr = rsp_q.pslverr;
      end
    end
  end

endmodule

// File: tb/tb_poci_arbiter.sv
`timescale 1ns/1ps
module tb_poci_arbiter;
  import pk_poci::*;

  localparam int TO = 4;

  logic pclk = 1'b0;
  logic presetn;

  if_poci m0_if ();
  if_poci m1_if ();
  if_poci s_if ();

  poci_arbiter #(.TIMEOUT(TO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Requester stimulus
  logic  rq_psel  [2];
  addr_t rq_addr  [2];
  logic  rq_write [2];
  data_t rq_wdata [2];
  bit    auto_req;

  // Target behaviour for the transfer in flight
  int    force_w;
  bit    force_rsp;
  data_t force_rdata;
  logic  force_err;
  int    cur_w;
  data_t cur_rdata;
  logic  cur_err;
  int    sl_acc;

  // Transaction-level model: a granted transfer occupies a fixed timeline
  // measured from its grant edge (t=1 SETUP, 2..1+ma ACCESS, 2+ma response).
  bit    mb;
  int    mt, ma, mg, mlast;
  bit    merr;
  addr_t maddr;
  logic  mwrite;
  data_t mwdata;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic apply_req();
    m0_if.psel    = rq_psel[0];
    m0_if.penable = rq_psel[0];
    m0_if.paddr   = rq_addr[0];
    m0_if.pwrite  = rq_write[0];
    m0_if.pwdata  = rq_wdata[0];
    m1_if.psel    = rq_psel[1];
    m1_if.penable = rq_psel[1];
    m1_if.paddr   = rq_addr[1];
    m1_if.pwrite  = rq_write[1];
    m1_if.pwdata  = rq_wdata[1];
  endtask

  task automatic model_check();
    bit    psel_e, pen_e, done_e, d0, d1;
    data_t rd_e;
    logic  err_e;
    psel_e = mb && (mt >= 1) && (mt <= 1 + ma);
    pen_e  = mb && (mt >= 2) && (mt <= 1 + ma);
    done_e = mb && (mt == 2 + ma);
    d0     = done_e && (mg == 0);
    d1     = done_e && (mg == 1);
    rd_e   = merr ? 32'h0 : cur_rdata;
    err_e  = merr ? 1'b1 : cur_err;
    chk1("s_psel", s_if.psel, psel_e);
    chk1("s_penable", s_if.penable, pen_e);
    if (psel_e) begin
      chk32("s_paddr", s_if.paddr, maddr);
      chk1("s_pwrite", s_if.pwrite, mwrite);
      chk32("s_pwdata", s_if.pwdata, mwdata);
    end
    chk1("m0_pready", m0_if.pready, d0);
    chk32("m0_prdata", m0_if.prdata, d0 ? rd_e : 32'h0);
    chk1("m0_pslverr", m0_if.pslverr, d0 ? err_e : 1'b0);
    chk1("m1_pready", m1_if.pready, d1);
    chk32("m1_prdata", m1_if.prdata, d1 ? rd_e : 32'h0);
    chk1("m1_pslverr", m1_if.pslverr, d1 ? err_e : 1'b0);
  endtask

  // Target answers on ACCESS cycle cur_w+1; junk data otherwise.
  task automatic slave_drive();
    if (s_if.psel === 1'b1 && s_if.penable === 1'b1) sl_acc++;
    else sl_acc = 0;
    if (sl_acc != 0 && sl_acc == cur_w + 1) begin
      s_if.pready  = 1'b1;
      s_if.prdata  = cur_rdata;
      s_if.pslverr = cur_err;
    end else begin
      s_if.pready  = 1'b0;
      s_if.prdata  = $urandom;
      s_if.pslverr = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic req_drive();
    for (int n = 0; n < 2; n++) begin
      logic rdy;
      rdy = (n == 0) ? m0_if.pready : m1_if.pready;
      if (rdy === 1'b1) begin
        rq_psel[n] = 1'b0;
      end else if (auto_req) begin
        if (!rq_psel[n]) begin
          if ($urandom_range(0, 2) == 0) begin
            rq_psel[n]  = 1'b1;
            rq_addr[n]  = $urandom;
            rq_write[n] = 1'($urandom_range(0, 1));
            rq_wdata[n] = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          rq_psel[n] = 1'b0;
        end
      end
    end
    apply_req();
  endtask

  task automatic model_advance();
    if (mb) begin
      if (mt == 2 + ma) mb = 1'b0;
      else mt++;
    end else if (rq_psel[0] || rq_psel[1]) begin
      if (rq_psel[0] && rq_psel[1]) mg = (mlast == 0) ? 1 : 0;
      else mg = rq_psel[1] ? 1 : 0;
      mlast     = mg;
      mb        = 1'b1;
      mt        = 1;
      maddr     = rq_addr[mg];
      mwrite    = rq_write[mg];
      mwdata    = rq_wdata[mg];
      cur_w     = (force_w >= 0) ? force_w : int'($urandom_range(0, 5));
      cur_rdata = force_rsp ? force_rdata : data_t'($urandom);
      cur_err   = force_rsp ? force_err : 1'($urandom_range(0, 1));
      merr      = (cur_w + 1 > TO);
      ma        = merr ? TO : cur_w + 1;
    end
  endtask

  task automatic step();
    @(negedge pclk);
    cyc++;
    model_check();
    slave_drive();
    req_drive();
    model_advance();
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    #1;
    chk1("rst_s_psel", s_if.psel, 1'b0);
    chk1("rst_s_penable", s_if.penable, 1'b0);
    chk32("rst_s_paddr", s_if.paddr, 32'h0);
    chk1("rst_s_pwrite", s_if.pwrite, 1'b0);
    chk32("rst_s_pwdata", s_if.pwdata, 32'h0);
    chk1("rst_m0_pready", m0_if.pready, 1'b0);
    chk32("rst_m0_prdata", m0_if.prdata, 32'h0);
    chk1("rst_m0_pslverr", m0_if.pslverr, 1'b0);
    chk1("rst_m1_pready", m1_if.pready, 1'b0);
    chk32("rst_m1_prdata", m1_if.prdata, 32'h0);
    chk1("rst_m1_pslverr", m1_if.pslverr, 1'b0);
    mb     = 1'b0;
    mlast  = 1;
    sl_acc = 0;
    cur_w  = 0;
    s_if.pready  = 1'b0;
    s_if.prdata  = '0;
    s_if.pslverr = 1'b0;
    for (int n = 0; n < 2; n++) rq_psel[n] = 1'b0;
    apply_req();
    @(negedge pclk);
    chk1("rst_hold_m0_pready", m0_if.pready, 1'b0);
    chk1("rst_hold_m1_pready", m1_if.pready, 1'b0);
    presetn = 1'b1;
  endtask

  task automatic run_until_done(input string tag, input int budget,
                                output int who, output int t_done, output int acc);
    bit seen;
    seen = 1'b0; who = -1; t_done = -1; acc = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (s_if.penable === 1'b1) acc++;
      if (m0_if.pready === 1'b1) begin
        who = 0; t_done = cyc; seen = 1'b1;
      end else if (m1_if.pready === 1'b1) begin
        who = 1; t_done = cyc; seen = 1'b1;
      end
    end
    chk1({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic set_req(input int n, input addr_t a, input logic w, input data_t d);
    rq_psel[n]  = 1'b1;
    rq_addr[n]  = a;
    rq_write[n] = w;
    rq_wdata[n] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int who, t0, t1, acc, k;
    presetn  = 1'b1;
    auto_req = 1'b0;
    force_w  = 0;
    force_rsp = 1'b1;
    force_rdata = '0;
    force_err = 1'b0;
    mb = 1'b0; mt = 0; ma = 1; mg = 0; mlast = 1; merr = 1'b0;
    maddr = '0; mwrite = 1'b0; mwdata = '0;
    cur_rdata = '0; cur_err = 1'b0; cur_w = 0; sl_acc = 0;
    for (int n = 0; n < 2; n++) begin
      rq_psel[n] = 1'b0; rq_addr[n] = '0; rq_write[n] = 1'b0; rq_wdata[n] = '0;
    end
    apply_req();
    s_if.pready = 1'b0; s_if.prdata = '0; s_if.pslverr = 1'b0;
    #2;
    do_reset();

    // m0 write, zero-wait target: exact cycle positions.
    force_w = 0; force_rsp = 1'b1; force_rdata = 32'h1234_5678; force_err = 1'b0;
    set_req(0, 32'h004, 1'b1, 32'h0000_00A5);
    step();
    step();
    chk1("w0_psel_k1", s_if.psel, 1'b1);
    chk1("w0_penable_k1", s_if.penable, 1'b0);
    chk32("w0_paddr_k1", s_if.paddr, 32'h004);
    chk32("w0_pwdata_k1", s_if.pwdata, 32'h0000_00A5);
    chk1("w0_pwrite_k1", s_if.pwrite, 1'b1);
    step();
    chk1("w0_penable_k2", s_if.penable, 1'b1);
    chk1("w0_m0_pready_k2", m0_if.pready, 1'b0);
    step();
    chk1("w0_m0_pready_k3", m0_if.pready, 1'b1);
    chk1("w0_m1_pready_k3", m1_if.pready, 1'b0);
    step();
    chk1("w0_m0_pready_k4", m0_if.pready, 1'b0);
    chk1("w0_psel_k4", s_if.psel, 1'b0);

    // Ties from reset: m0, then m1 after one idle cycle, then m0 again.
    do_reset();
    set_req(0, 32'h100, 1'b1, 32'h1111_0000);
    set_req(1, 32'h200, 1'b1, 32'h2222_0000);
    step(); k = cyc;
    run_until_done("tie1", 20, who, t0, acc);
    chk_int("tie1_winner", who, 0);
    chk_int("tie1_cycle", t0, k + 3);
    run_until_done("tie1b", 20, who, t1, acc);
    chk_int("tie1b_winner", who, 1);
    chk_int("tie1b_spacing", t1, t0 + 4);
    set_req(0, 32'h104, 1'b0, 32'h0);
    set_req(1, 32'h204, 1'b0, 32'h0);
    step(); k = cyc;
    run_until_done("tie2", 20, who, t0, acc);
    chk_int("tie2_winner", who, 0);
    chk_int("tie2_cycle", t0, k + 3);
    run_until_done("tie2b", 20, who, t1, acc);
    chk_int("tie2b_winner", who, 1);

    // m1 read with 3 wait states; answer lands on the last allowed cycle.
    force_w = 3; force_rdata = 32'hDEAD_BEEF; force_err = 1'b0;
    set_req(1, 32'h0C8, 1'b0, 32'h0);
    step(); k = cyc;
    run_until_done("rd3", 30, who, t0, acc);
    chk_int("rd3_who", who, 1);
    chk_int("rd3_cycle", t0, k + 6);
    chk_int("rd3_access_cycles", acc, 4);
    chk32("rd3_prdata", m1_if.prdata, 32'hDEAD_BEEF);
    chk1("rd3_pslverr", m1_if.pslverr, 1'b0);

    // Target never answers: timeout error, then a normal transfer.
    force_w = 1000; force_rsp = 1'b0;
    set_req(0, 32'h0F0, 1'b1, 32'hCAFE_0001);
    step(); k = cyc;
    run_until_done("tmo", 30, who, t0, acc);
    chk_int("tmo_who", who, 0);
    chk_int("tmo_cycle", t0, k + 6);
    chk_int("tmo_access_cycles", acc, 4);
    chk32("tmo_prdata", m0_if.prdata, 32'h0);
    chk1("tmo_pslverr", m0_if.pslverr, 1'b1);
    force_w = 0; force_rsp = 1'b1; force_rdata = 32'h0000_0042; force_err = 1'b0;
    set_req(1, 32'h0F4, 1'b0, 32'h0);
    step(); k = cyc;
    run_until_done("post_tmo", 20, who, t0, acc);
    chk_int("post_tmo_who", who, 1);
    chk_int("post_tmo_cycle", t0, k + 3);
    chk1("post_tmo_pslverr", m1_if.pslverr, 1'b0);
    chk32("post_tmo_prdata", m1_if.prdata, 32'h0000_0042);

    // Reset in ACCESS after an m0 grant; afterwards a tie must go to m0.
    force_w = 1000;
    set_req(0, 32'h300, 1'b1, 32'h3333_3333);
    step();
    step();
    step();
    chk1("abort_in_access", s_if.penable, 1'b1);
    do_reset();
    force_w = 0;
    set_req(0, 32'h400, 1'b1, 32'h4);
    set_req(1, 32'h500, 1'b1, 32'h5);
    step(); k = cyc;
    run_until_done("rst_tie", 20, who, t0, acc);
    chk_int("rst_tie_winner", who, 0);
    chk_int("rst_tie_cycle", t0, k + 3);
    run_until_done("rst_tie_b", 20, who, t1, acc);
    chk_int("rst_tie_b_winner", who, 1);

    // Random traffic against the model.
    force_w = -1; force_rsp = 1'b0; auto_req = 1'b1;
    for (int i = 0; i < 2000; i++) step();
    auto_req = 1'b0;
    for (int n = 0; n < 2; n++) rq_psel[n] = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poci_arbiter.md
POCI_ARBITER -- requirements
Module: poci_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning ACCESS-phase cycles to wait for pready before the arbiter ends the transfer with an error (range 1..255).
REQ-002 SHALL have port pclk, input, 1, the single POCI clock; all state changes on its rising edge.
REQ-003 SHALL have port presetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port m0, if_poci slave side, pk_poci widths, requester 0.
REQ-005 SHALL have port m1, if_poci slave side, pk_poci widths, requester 1.
REQ-006 SHALL have port s, if_poci master side, pk_poci widths, the shared POCI target.

Function
REQ-007 SHALL implement states IDLE, SETUP, ACCESS, DONE.
REQ-008 A request on requester n SHALL be defined as mn.psel=1 sampled in IDLE; mn.penable is not used for arbitration.
REQ-009 In IDLE with one request, that requester SHALL be granted, its paddr/pwrite/pwdata registered, and the state SHALL go to SETUP.
REQ-010 In IDLE with both requesting, the requester not granted last SHALL win; last_grant resets to 1, so m0 wins the first tie.
REQ-011 In SETUP, s.psel=1, s.penable=0 and s.paddr/pwrite/pwdata = registered values; the state SHALL go to ACCESS on the next edge.
REQ-012 In ACCESS, s.psel=1 and s.penable=1; the registered values SHALL be held stable until the state leaves ACCESS.
REQ-013 In ACCESS with s.pready=1, s.prdata and s.pslverr SHALL be latched and the state SHALL go to DONE.
REQ-014 The ACCESS cycle counter SHALL be 8 bits and clear on entry to SETUP.
REQ-015 If the counter reaches TIMEOUT without s.pready, the state SHALL go to DONE with latched pslverr=1 and prdata=0.
REQ-016 If s.pready and the timeout occur in the same cycle, s.pready SHALL win and the slave response is used.
REQ-017 In DONE, the granted requester SHALL see pready=1 for exactly one cycle with the latched prdata/pslverr, and the state SHALL go to IDLE.
REQ-018 Outside DONE, and always for the non-granted requester, pready=0, prdata=0 and pslverr=0.
REQ-019 If the granted requester drops psel mid-transfer, the slave transfer SHALL still complete and the DONE pulse SHALL still be issued.
REQ-020 Latency SHALL be as follows: request seen at edge k puts s.psel=1 in cycle k+1 and s.penable=1 in cycle k+2. With zero-wait pready, requester pready=1 is in cycle k+3.
REQ-021 One IDLE cycle SHALL separate consecutive transfers; peak throughput is one transfer per 4 cycles.
REQ-022 s.psel SHALL never be asserted in IDLE or DONE.

Reset
REQ-023 presetn=0 SHALL immediately force state=IDLE, s.psel=0, s.penable=0, s.paddr=0, s.pwrite=0, s.pwdata=0, all requester pready/prdata/pslverr=0, counter=0 and last_grant=1.
REQ-024 Reset mid-transfer SHALL abort it with no response pulse; after release, the first edge samples requests as in IDLE.

Structure
REQ-025 State enum, POCI address/data widths and the default timeout constant SHALL live in pk_poci.
REQ-026 The block SHALL be a single module; no sub-module is required.
REQ-027 The round-robin grant SHALL be coded as one always_comb function of the requests and last_grant.

Verification
REQ-028 m0 write paddr=0x004, pwdata=0x0000_00A5, zero-wait slave -> s.psel in k+1, s.penable in k+2, m0.pready=1 only in k+3, m1.pready=0 throughout.
REQ-029 m0 and m1 request together from reset -> m0 served first; m1 served next with one IDLE cycle between; a second tie goes to m0 again.
REQ-030 m1 read, slave inserts 3 wait states, prdata=0xDEAD_BEEF -> m1.pready after ACCESS cycle 4 with prdata=0xDEAD_BEEF, pslverr=0; paddr stable through all ACCESS cycles.
REQ-031 TIMEOUT=4, slave never asserts pready -> after 4 ACCESS cycles requester sees pready=1, pslverr=1, prdata=0; the next request is served normally.
REQ-032 presetn pulsed low during ACCESS -> s.psel/s.penable drop asynchronously, no requester pready, next request served from m0 tie priority.
